// File: rtl/output_writeback_ctrl.sv
// rtl/output_writeback_ctrl.sv - result-word FIFO and dual-port write packer for the output memory
// Buffers upstream words and issues them as address/data pairs on two write ports per job.
module output_writeback_ctrl #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        tile_count,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic [ADDR_W-1:0] addr_1_out,
  output logic [DATA_W-1:0] data_1_out,
  output logic              package_1_valid_out,
  output logic [ADDR_W-1:0] addr_2_out,
  output logic [DATA_W-1:0] data_2_out,
  output logic              package_2_valid_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        words_written
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        accepted;
  logic [7:0]        tile_q;
  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        pop_n;
  logic              push;
  logic              job_start;

  // Ready depends only on registered state so upstream valid never loops back combinationally.
  assign res_ready = (state == S_RUN) && (fifo_count < DEPTH_C) && (accepted < tile_q);
  assign push      = res_valid && res_ready;
  assign job_start = (state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = (tile_count == 8'd0) ? S_DONE : S_RUN;
      S_RUN:  if ((pop_n != 2'd0) && ((words_written + 8'(pop_n)) == tile_q)) state_n = S_LAST;
      S_LAST: state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // A lone word is only flushed once the whole job has arrived; otherwise wait to pair it.
  always_comb begin
    pop_n = 2'd0;
    if (state == S_RUN) begin
      if (fifo_count >= TWO_C)                             pop_n = 2'd2;
      else if ((fifo_count == ONE_C) && (accepted == tile_q)) pop_n = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_count          <= '0;
      accepted            <= '0;
      tile_q              <= '0;
      next_addr           <= '0;
      words_written       <= '0;
      addr_1_out          <= '0;
      data_1_out          <= '0;
      package_1_valid_out <= 1'b0;
      addr_2_out          <= '0;
      data_2_out          <= '0;
      package_2_valid_out <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      package_1_valid_out <= (pop_n != 2'd0);
      package_2_valid_out <= (pop_n == 2'd2);
      busy                <= (state_n != S_IDLE);
      done                <= (state_n == S_DONE);
      if (job_start) begin
        tile_q        <= tile_count;
        next_addr     <= base_addr;
        accepted      <= '0;
        words_written <= '0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        fifo_count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          accepted <= accepted + 8'd1;
        end
        if (pop_n != 2'd0) begin
          addr_1_out    <= next_addr;
          data_1_out    <= fifo_mem[rd_ptr];
          rd_ptr        <= rd_ptr + PTR_W'(pop_n);
          next_addr     <= next_addr + ADDR_W'(pop_n);
          words_written <= words_written + 8'(pop_n);
        end
        if (pop_n == 2'd2) begin
          addr_2_out <= next_addr + 1'b1;
          data_2_out <= fifo_mem[rd_ptr + 1'b1];
        end
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop_n);
      end
    end
  end

endmodule

// File: tb/tb_output_writeback_ctrl.sv
// tb/tb_output_writeback_ctrl.sv - directed self-checking bench for output_writeback_ctrl
module tb_output_writeback_ctrl;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        tile_count;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic [ADDR_W-1:0] addr_1_out;
  logic [DATA_W-1:0] data_1_out;
  logic              package_1_valid_out;
  logic [ADDR_W-1:0] addr_2_out;
  logic [DATA_W-1:0] data_2_out;
  logic              package_2_valid_out;
  logic              busy;
  logic              done;
  logic [7:0]        words_written;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  output_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .tile_count(tile_count),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .addr_1_out(addr_1_out), .data_1_out(data_1_out), .package_1_valid_out(package_1_valid_out),
    .addr_2_out(addr_2_out), .data_2_out(data_2_out), .package_2_valid_out(package_2_valid_out),
    .busy(busy), .done(done), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(i * 32'h0101_0007);
    return {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pkg(input string tag,
                     input logic ev1, input logic [ADDR_W-1:0] ea1, input logic [DATA_W-1:0] ed1,
                     input logic ev2, input logic [ADDR_W-1:0] ea2, input logic [DATA_W-1:0] ed2);
    chk({tag, ".v1"}, DATA_W'(package_1_valid_out), DATA_W'(ev1));
    chk({tag, ".v2"}, DATA_W'(package_2_valid_out), DATA_W'(ev2));
    if (ev1) begin
      chk({tag, ".a1"}, DATA_W'(addr_1_out), DATA_W'(ea1));
      chk({tag, ".d1"}, data_1_out, ed1);
    end
    if (ev2) begin
      chk({tag, ".a2"}, DATA_W'(addr_2_out), DATA_W'(ea2));
      chk({tag, ".d2"}, data_2_out, ed2);
    end
  endtask

  task automatic ctl(input string tag, input logic eready, input logic ebusy, input logic edone);
    chk({tag, ".ready"}, DATA_W'(res_ready), DATA_W'(eready));
    chk({tag, ".busy"},  DATA_W'(busy),      DATA_W'(ebusy));
    chk({tag, ".done"},  DATA_W'(done),      DATA_W'(edone));
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; tile_count = '0;
    res_valid = 1'b1; res_data = mk(99);

    // reset held with valid high
    repeat (3) cyc();
    ctl("rst", 1'b0, 1'b0, 1'b0);
    pkg("rst", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    chk("rst.a1", DATA_W'(addr_1_out), '0);
    chk("rst.d1", data_1_out, '0);
    chk("rst.ww", DATA_W'(words_written), '0);
    reset = 1'b1; res_valid = 1'b0;
    cyc();

    // job A: base 0x10, 4 words back to back
    start = 1'b1; base_addr = 8'h10; tile_count = 8'd4;
    cyc();
    ctl("a.run", 1'b1, 1'b1, 1'b0);
    start = 1'b0; res_valid = 1'b1; res_data = mk(0);
    cyc();
    res_data = mk(1);
    cyc();
    pkg("a.e2", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    res_data = mk(2);
    cyc();
    pkg("a.p0", 1'b1, 8'h10, mk(0), 1'b1, 8'h11, mk(1));
    res_data = mk(3);
    cyc();
    pkg("a.e4", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    chk("a.ready_full", DATA_W'(res_ready), '0);
    res_valid = 1'b0;
    cyc();
    pkg("a.p1", 1'b1, 8'h12, mk(2), 1'b1, 8'h13, mk(3));
    chk("a.nodone", DATA_W'(done), '0);
    cyc();
    ctl("a.done", 1'b0, 1'b1, 1'b1);
    pkg("a.e6", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    chk("a.ww", DATA_W'(words_written), DATA_W'(8'd4));
    cyc();
    ctl("a.idle", 1'b0, 1'b0, 1'b0);
    chk("a.ww_hold", DATA_W'(words_written), DATA_W'(8'd4));

    // job B: base 0xFF wraps, odd count
    start = 1'b1; base_addr = 8'hFF; tile_count = 8'd3;
    cyc();
    start = 1'b0; res_valid = 1'b1; res_data = mk(10);
    cyc();
    res_data = mk(11);
    cyc();
    res_data = mk(12);
    cyc();
    pkg("b.p0", 1'b1, 8'hFF, mk(10), 1'b1, 8'h00, mk(11));
    res_valid = 1'b0;
    cyc();
    pkg("b.p1", 1'b1, 8'h01, mk(12), 1'b0, 8'h00, '0);
    cyc();
    ctl("b.done", 1'b0, 1'b1, 1'b1);
    chk("b.ww", DATA_W'(words_written), DATA_W'(8'd3));
    cyc();

    // job C: zero-length
    start = 1'b1; base_addr = 8'h55; tile_count = 8'd0;
    cyc();
    start = 1'b0;
    ctl("c.done", 1'b0, 1'b1, 1'b1);
    pkg("c.e0", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    chk("c.ww", DATA_W'(words_written), '0);
    cyc();
    ctl("c.idle", 1'b0, 1'b0, 1'b0);
    pkg("c.e1", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);

    // job D: bubbly upstream, stray start mid-job, valid held high afterwards
    start = 1'b1; base_addr = 8'h20; tile_count = 8'd3;
    cyc();
    start = 1'b0; res_valid = 1'b1; res_data = mk(20);
    cyc();
    res_valid = 1'b0; res_data = mk(77);
    start = 1'b1; base_addr = 8'h80; tile_count = 8'd7;
    cyc();
    start = 1'b0;
    ctl("d.bubble", 1'b1, 1'b1, 1'b0);
    pkg("d.bubble", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    cyc();
    res_valid = 1'b1; res_data = mk(21);
    cyc();
    res_data = mk(22);
    cyc();
    pkg("d.p0", 1'b1, 8'h20, mk(20), 1'b1, 8'h21, mk(21));
    res_data = mk(88);
    cyc();
    pkg("d.p1", 1'b1, 8'h22, mk(22), 1'b0, 8'h00, '0);
    cyc();
    ctl("d.done", 1'b0, 1'b1, 1'b1);
    chk("d.ww", DATA_W'(words_written), DATA_W'(8'd3));
    for (int i = 0; i < 3; i++) begin
      cyc();
      ctl("d.idle", 1'b0, 1'b0, 1'b0);
      pkg("d.idle", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    end
    res_valid = 1'b0;

    // job E: reset after 2 of 6 words, then a fresh job
    start = 1'b1; base_addr = 8'h30; tile_count = 8'd6;
    cyc();
    start = 1'b0; res_valid = 1'b1; res_data = mk(30);
    cyc();
    res_data = mk(31);
    cyc();
    reset = 1'b0;
    cyc();
    ctl("e.rst", 1'b0, 1'b0, 1'b0);
    pkg("e.rst", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    chk("e.rst.a1", DATA_W'(addr_1_out), '0);
    chk("e.rst.ww", DATA_W'(words_written), '0);
    reset = 1'b1; res_valid = 1'b0;
    start = 1'b1; base_addr = 8'h40; tile_count = 8'd2;
    cyc();
    start = 1'b0; res_valid = 1'b1; res_data = mk(40);
    cyc();
    res_data = mk(41);
    cyc();
    pkg("e.e2", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    res_valid = 1'b0;
    cyc();
    pkg("e.p0", 1'b1, 8'h40, mk(40), 1'b1, 8'h41, mk(41));
    cyc();
    pkg("e.last", 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
    ctl("e.done", 1'b0, 1'b1, 1'b1);
    chk("e.ww", DATA_W'(words_written), DATA_W'(8'd2));
    cyc();
    ctl("e.idle", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/output_writeback_ctrl.md
# output_writeback_ctrl

Upstream feeder for the output memory. It accepts 512-bit result words from the Winograd output-transform stage over a valid/ready handshake and buffers them in a small FIFO. It then packs the words into address/data/valid packages on the output memory's two write ports, so two consecutive addresses are written per issue. One job is one `start` pulse: a base address plus a word count. The block reports progress and signals completion with a done pulse.

## Interface
- `DATA_W`, 512, width of one result word / memory row
- `ADDR_W`, 8, memory package address width
- `FIFO_DEPTH`, 4, result buffer entries (power of two, ≥2)

- `clk`  in  1  single clock for the block
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on rising `clk`
- `start`  in  1  job start pulse; honoured only in IDLE
- `base_addr`  in  ADDR_W  first write address, latched on `start`
- `tile_count`  in  8  number of words in the job, latched on `start`
- `res_valid`  in  1  upstream word valid
- `res_data`  in  DATA_W  upstream word
- `res_ready`  out  1  block can accept a word this cycle
- `addr_1_out`, `data_1_out`, `package_1_valid_out`  out  ADDR_W / DATA_W / 1  port-1 write package to output memory
- `addr_2_out`, `data_2_out`, `package_2_valid_out`  out  ADDR_W / DATA_W / 1  port-2 write package to output memory
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle job-complete pulse
- `words_written`  out  8  words issued in the current or last job

## Operation
- States:
  - IDLE: `start` with `tile_count`=0 goes to DONE; `start` with `tile_count`>0 goes to RUN.
  - RUN: goes to LAST at the edge that pops the final word(s).
  - LAST: goes to DONE.
  - DONE: goes to IDLE.
- On `start`: latch the job, set `next_addr`=`base_addr`, and clear `accepted`, `words_written` and the FIFO.
- `res_ready` = (state==RUN) && (fifo_count<FIFO_DEPTH) && (accepted<tile_count). It uses registered values only, with no combinational path from `res_valid`.
- A handshake (`res_valid`&&`res_ready`) enqueues `res_data` and increments `accepted`.
- Issue rule, evaluated every RUN cycle on registered `fifo_count` and `accepted`:
  - If count≥2: pop two words. The head goes to port 1 at `next_addr`; the second goes to port 2 at `next_addr`+1.
  - Else if count==1 and `accepted`==`tile_count`: pop one word to port 1 only, with port 2 valid 0.
  - Otherwise: no pop.
- Enqueue and pop in the same cycle are legal.
- `next_addr` and `words_written` advance by the number popped. Address arithmetic is modulo 2^ADDR_W (port 2 of a pair may wrap to 0).
- `done` is high only in DONE. `busy` is high in RUN, LAST and DONE.
- `start` outside IDLE is ignored. `res_valid` outside RUN is never accepted (`res_ready`=0).
- Reset, including mid-job: state IDLE; FIFO, `accepted`, `next_addr` and `words_written` cleared; all outputs 0.

## Timing
- All outputs are registered.
- A package produced by a pop at edge N is visible during the cycle after N, with its valid high for exactly that cycle.
- When no pop occurs, valids are 0 and addr/data hold their last values. Data is don't-care when the matching valid is 0.
- Minimum latency is 2 edges:
  - A word accepted at edge N is popped at edge N+1 at the earliest.
  - It is seen on the ports in the cycle after N+1.
- Sustained throughput is 1 word/cycle in, issued as pairs every second cycle. FIFO occupancy never exceeds 2 under this rule; depth 4 gives margin.
- `done` asserts one cycle after the final package cycle (LAST). `busy` drops the cycle after `done`.
- `tile_count`=0: `done` is high in the cycle after the `start` edge, and no packages are issued.
- `words_written` holds its final value until the next `start` or reset.

## Test plan
- Reset held low for 3 cycles with `res_valid`=1 -> all outputs 0, `res_ready`=0, `busy`=0.
- `start`, `base_addr`=0x10, `tile_count`=4; D0..D3 accepted on 4 consecutive edges:
  - one cycle: port1 {0x10,D0} and port2 {0x11,D1} valid together;
  - two cycles later: {0x12,D2} / {0x13,D3};
  - `done` pulses one cycle after the last pair, `words_written`=4.
- `base_addr`=0xFF, `tile_count`=3:
  - pair {0xFF,D0}/{0x00,D1};
  - then port1 {0x01,D2} with `package_2_valid_out`=0;
  - `words_written`=3.
- `tile_count`=0 -> `done` high the cycle after `start`, no package valid ever asserted, `busy` high for exactly 1 cycle.
- Bubbly upstream (`res_valid` 1,0,0,1,1 over `tile_count`=3); `start` pulsed again mid-job; `res_valid` held high in IDLE:
  - packages are correct and contiguous from the original base;
  - the second `start` is ignored;
  - no acceptance occurs in IDLE.
- Reset asserted after 2 of 6 words are accepted -> next cycle all outputs 0 and FIFO empty; a new job (`base_addr`=0x40, `tile_count`=2) then writes only 0x40/0x41 with the new data.
